// File: rtl/clut_write_queue.sv
// Queues CLUT colour writes from the ICA/DCA register port until the RAM write
// port is free; all other register writes are forwarded one cycle later.
module clut_write_queue #(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [6:0]            register_adr,
   input  logic [23:0]           register_data,
   input  logic                  register_write,
   input  logic                  clut_wr_allow,
   output logic                  clut_we,
   output logic [7:0]            clut_adr,
   output logic [23:0]           clut_rgb,
   output logic [6:0]            reg_adr_o,
   output logic [23:0]           reg_data_o,
   output logic                  reg_write_o,
   output logic [1:0]            clut_bank,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] ONE_LEVEL  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [6:0]          BANK_ADR   = 7'h43;

   logic [31:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;

   logic       write_ok;
   logic       colour_wr;
   logic       bank_wr;
   logic       fwd_wr;
   logic       full;
   logic       pop;
   logic       push;
   logic       drop;
   logic [7:0] colour_idx;

   // Writes presented while reset is high are masked out entirely.
   always_comb begin
      write_ok   = register_write && !reset;
      colour_wr  = write_ok && (register_adr[6] == 1'b0);
      bank_wr    = write_ok && (register_adr == BANK_ADR);
      fwd_wr     = write_ok && register_adr[6];
      full       = (level == FULL_LEVEL);
      pop        = !reset && clut_wr_allow && (level != '0);
      push       = colour_wr && (!full || pop);
      drop       = colour_wr && full && !pop;
      colour_idx = {clut_bank, register_adr[5:0]};
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {colour_idx, register_data};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + ONE_LEVEL;
            2'b01:   level <= level - ONE_LEVEL;
            default: level <= level;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Bank register updates after the edge, so a same-cycle colour write uses the old bank.
   always_ff @(posedge clk) begin
      if (reset) begin
         clut_bank <= '0;
      end else if (bank_wr) begin
         clut_bank <= register_data[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         clut_we  <= 1'b0;
         clut_adr <= '0;
         clut_rgb <= '0;
      end else begin
         clut_we <= pop;
         if (pop) begin
            {clut_adr, clut_rgb} <= mem[rd_ptr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reg_write_o <= 1'b0;
         reg_adr_o   <= '0;
         reg_data_o  <= '0;
      end else begin
         reg_write_o <= fwd_wr;
         if (fwd_wr) begin
            reg_adr_o  <= register_adr;
            reg_data_o <= register_data;
         end
      end
   end

endmodule

// File: doc/clut_write_queue.md
CLUT_WRITE_QUEUE -- requirements
Module: clut_write_queue

Interface
REQ-001 Parameter: DEPTH_LOG2, 4, queue depth is 2**DEPTH_LOG2 entries (16).
REQ-002 Ports: clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-003 Ports: reset  in  1  synchronous, active-high reset.
REQ-004 Ports: register_adr  in  7  register address from the ICA/DCA controller; full command code is {1'b1, register_adr}.
REQ-005 Ports: register_data  in  24  register write payload.
REQ-006 Ports: register_write  in  1  one-cycle strobe qualifying register_adr/register_data.
REQ-007 Ports: clut_wr_allow  in  1  high while the CLUT RAM write port is free (horizontal/vertical blank).
REQ-008 Ports: clut_we  out  1  CLUT RAM write enable.
REQ-009 Ports: clut_adr  out  8  CLUT RAM entry index, {bank[1:0], colour[5:0]}.
REQ-010 Ports: clut_rgb  out  24  CLUT RAM write data, R[23:16] G[15:8] B[7:0].
REQ-011 Ports: reg_adr_o  out  7  forwarded non-CLUT register address.
REQ-012 Ports: reg_data_o  out  24  forwarded non-CLUT register data.
REQ-013 Ports: reg_write_o  out  1  forwarded non-CLUT write strobe.
REQ-014 Ports: clut_bank  out  2  current CLUT bank.
REQ-015 Ports: level  out  DEPTH_LOG2+1  current queue occupancy, 0..16.
REQ-016 Ports: overflow  out  1  sticky flag, set when a CLUT write was dropped.

Function
REQ-017 Decode: a register_write with register_adr in 0x00..0x3F (command 0x80..0xBF) SHALL be a colour write; index = {clut_bank, register_adr[5:0]}.
REQ-018 Decode: a register_write with register_adr == 0x43 (command 0xC3) SHALL load clut_bank <= register_data[1:0] on the next edge.
REQ-019 Decode: a register_write whose address is not a colour write (including 0x43) SHALL be forwarded on reg_*_o exactly one cycle later.
REQ-020 Decode: forwarded outputs SHALL be registered; reg_write_o SHALL be a single-cycle pulse.
REQ-021 Bank ordering: a colour write SHALL use the bank value in effect before the edge. A bank write in cycle N therefore affects colour writes from cycle N+1 onwards.
REQ-022 Push: a colour write SHALL push {index, register_data} into the FIFO when level < 16.
REQ-023 Full: a colour write at level == 16 with no simultaneous pop SHALL be dropped and SHALL set overflow.
REQ-024 Full: if a pop occurs in the same cycle as a colour write at level 16, the push SHALL succeed and level SHALL stay 16.
REQ-025 Overflow clearing: overflow SHALL clear only on reset.
REQ-026 Pop: when clut_wr_allow=1 and level>0, one entry SHALL be popped per cycle.
REQ-027 Pop output: a popped entry SHALL appear registered the following cycle, with clut_we=1 and clut_adr/clut_rgb holding that entry; otherwise clut_we=0.
REQ-028 Drain order: entries SHALL drain in FIFO order at a sustained rate of one per cycle while clut_wr_allow stays high.
REQ-029 Empty: level == 0 SHALL produce no pop, even when clut_wr_allow=1.
REQ-030 Simultaneous push and pop below full: level SHALL be unchanged.
REQ-031 Bypass: the FIFO SHALL NOT be bypassed. The minimum latency from a colour write to clut_we is 2 cycles (push edge, then pop edge).
REQ-032 Pointers: read and write pointers SHALL be DEPTH_LOG2 bits and wrap modulo 16. level SHALL be maintained as a separate counter, never derived from pointer difference alone.
REQ-033 Drain gating: deassertion of clut_wr_allow SHALL stop pops at the next edge. An entry already registered on the output completes its clut_we cycle.

Reset
REQ-034 Reset values: on reset, level, pointers, clut_bank, overflow, clut_we and reg_write_o SHALL be 0. clut_adr, clut_rgb, reg_adr_o and reg_data_o SHALL be 0.
REQ-035 Reset mid-operation: reset while entries are queued or draining SHALL discard them. No clut_we SHALL occur in the cycle after reset is sampled high.
REQ-036 Input masking: register_write SHALL be ignored in any cycle where reset is high.

Verification
REQ-037 Bank and push: write 0x43 data 0x000002, then adr 0x05 data 0x123456, with clut_wr_allow=0 -> level=1. Then raise clut_wr_allow -> clut_we=1, clut_adr=0x85, clut_rgb=0x123456 exactly one cycle later, and level=0.
REQ-038 Forwarding: write adr 0x40 data 0xABCDEF -> reg_write_o=1, reg_adr_o=0x40, reg_data_o=0xABCDEF for one cycle. level remains 0.
REQ-039 Full and overflow: 17 colour writes with clut_wr_allow=0 -> level=16 and overflow=1. Draining outputs the first 16 writes in order; the 17th is absent.
REQ-040 Full with pop: at level 16, assert clut_wr_allow together with a colour write -> level stays 16, overflow stays 0, and the new entry is later output in FIFO order.
REQ-041 Wrap-around: 40 colour writes with clut_wr_allow=1 continuously -> 40 clut_we pulses in order, level never exceeds 1, and overflow=0.
REQ-042 Reset mid-drain: 5 entries queued, drain 2, then assert reset for one cycle -> level=0, clut_we=0 thereafter, and clut_bank=0.
